// File: rtl/traffic_pkg.sv
// Shared types for the traffic conflict monitor.
// States, fault codes and the per-direction lamp bundle.
package traffic_pkg;

  typedef enum logic [1:0] {
    STARTUP,
    MONITOR,
    FAULT_FLASH
  } state_t;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_CONFLICT  = 2'b01;
  localparam logic [1:0] FC_INVALID   = 2'b10;
  localparam logic [1:0] FC_SHORT_YEL = 2'b11;

  typedef struct packed {
    logic green;
    logic left_green;
    logic yellow;
    logic red;
  } lamps_t;

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp command/drive bundle between controller, monitor and field.
// The master side drives the commands; the slave side is the monitor.
interface traffic_conflict_monitor_if;

  logic       in_ns_green;
  logic       in_ns_left_green;
  logic       in_ns_yellow;
  logic       in_ns_red;
  logic       in_ew_green;
  logic       in_ew_left_green;
  logic       in_ew_yellow;
  logic       in_ew_red;
  logic       clear_fault;
  logic       ns_green;
  logic       ns_left_green;
  logic       ns_yellow;
  logic       ns_red;
  logic       ew_green;
  logic       ew_left_green;
  logic       ew_yellow;
  logic       ew_red;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output in_ns_green, in_ns_left_green,
    output in_ns_yellow, in_ns_red,
    output in_ew_green, in_ew_left_green,
    output in_ew_yellow, in_ew_red,
    output clear_fault,
    input  ns_green, ns_left_green,
    input  ns_yellow, ns_red,
    input  ew_green, ew_left_green,
    input  ew_yellow, ew_red,
    input  fault, fault_code
  );

  modport slave (
    input  in_ns_green, in_ns_left_green,
    input  in_ns_yellow, in_ns_red,
    input  in_ew_green, in_ew_left_green,
    input  in_ew_yellow, in_ew_red,
    input  clear_fault,
    output ns_green, ns_left_green,
    output ns_yellow, ns_red,
    output ew_green, ew_left_green,
    output ew_yellow, ew_red,
    output fault, fault_code
  );

endinterface

// File: rtl/traffic_dir_checker.sv
// Aspect validity and yellow-interval check for one direction.
// The yellow timer only runs while monitoring is enabled.
module traffic_dir_checker #(
    parameter int MIN_YELLOW = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic green,
    input  logic left_green,
    input  logic yellow,
    input  logic red,
    output logic go,
    output logic valid,
    output logic short_yellow
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW);

    logic [YW-1:0] ytmr;

    assign go = green | left_green;

    // xor is set for one or three active aspects; drop the three case
    assign valid = (go ^ yellow ^ red) & ~(go & yellow & red);

    // a nonzero timer with yellow now low means yellow just fell
    assign short_yellow = en & ~yellow
                        & (ytmr != '0) & (ytmr < Y_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ytmr <= '0;
        else if (!en || !yellow)
            ytmr <= '0;
        else if (ytmr != Y_MAX)
            ytmr <= ytmr + YW'(1);
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp command monitor: passes commands through, latches faults
// and overrides the field with all-red flash until cleared.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int CONFLICT_CYCLES = 3,
    parameter int MIN_YELLOW      = 30,
    parameter int FLASH_HALF      = 50,
    parameter int STARTUP_CYCLES  = 20
) (
    input logic clk,
    input logic rst,
    traffic_conflict_monitor_if.slave bus
);

    localparam int PW = $clog2(CONFLICT_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam logic [PW-1:0] P_MAX = PW'(CONFLICT_CYCLES);
    localparam logic [PW-1:0] P_HIT = PW'(CONFLICT_CYCLES - 1);
    localparam logic [FW-1:0] F_END = FW'(FLASH_HALF - 1);
    localparam logic [SW-1:0] S_END = SW'(STARTUP_CYCLES - 1);
    localparam lamps_t ALL_RED = lamps_t'(4'b0001);

    state_t        state, state_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [PW-1:0] persist, persist_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          flash, flash_n;
    logic [1:0]    code, code_n, det_code;
    lamps_t        ns_q, ns_n, ew_q, ew_n;
    lamps_t        ns_in, ew_in;
    logic          mon, ns_go, ew_go, ns_valid, ew_valid;
    logic          ns_sy, ew_sy;
    logic          conflict, bad, hit, short_yel;
    logic          c_conf, c_sy, c_inv, clear_ok;

    assign ns_in = lamps_t'({bus.in_ns_green, bus.in_ns_left_green,
                             bus.in_ns_yellow, bus.in_ns_red});
    assign ew_in = lamps_t'({bus.in_ew_green, bus.in_ew_left_green,
                             bus.in_ew_yellow, bus.in_ew_red});
    assign mon   = (state == MONITOR);

    traffic_dir_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns (
        .clk(clk), .rst(rst), .en(mon),
        .green(ns_in.green), .left_green(ns_in.left_green),
        .yellow(ns_in.yellow), .red(ns_in.red),
        .go(ns_go), .valid(ns_valid), .short_yellow(ns_sy)
    );

    traffic_dir_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew (
        .clk(clk), .rst(rst), .en(mon),
        .green(ew_in.green), .left_green(ew_in.left_green),
        .yellow(ew_in.yellow), .red(ew_in.red),
        .go(ew_go), .valid(ew_valid), .short_yellow(ew_sy)
    );

    assign conflict  = ns_go & ew_go;
    assign bad       = conflict | ~ns_valid | ~ew_valid;
    assign hit       = mon & bad & (persist == P_HIT);
    assign short_yel = ns_sy | ew_sy;

    // exclusive terms encode conflict > short yellow > invalid
    assign c_conf = hit & conflict;
    assign c_sy   = short_yel & ~c_conf;
    assign c_inv  = hit & ~conflict & ~short_yel;

    assign clear_ok = bus.clear_fault & ns_valid & ew_valid
                    & ~conflict & ns_in.red & ew_in.red;

    always_comb begin
        det_code = FC_NONE;
        unique case (1'b1)
            c_conf:  det_code = FC_CONFLICT;
            c_sy:    det_code = FC_SHORT_YEL;
            c_inv:   det_code = FC_INVALID;
            default: det_code = FC_NONE;
        endcase
    end

    always_comb begin
        state_n   = state;
        scnt_n    = '0;
        persist_n = '0;
        fcnt_n    = '0;
        flash_n   = 1'b1;
        code_n    = code;
        ns_n      = ALL_RED;
        ew_n      = ALL_RED;
        unique case (state)
            STARTUP: begin
                if (scnt == S_END) state_n = MONITOR;
                else scnt_n = scnt + SW'(1);
            end
            MONITOR: begin
                ns_n = ns_in;
                ew_n = ew_in;
                if (bad)
                    persist_n = (persist == P_MAX) ? persist
                                                   : persist + PW'(1);
                if (det_code != FC_NONE) begin
                    state_n = FAULT_FLASH;
                    code_n  = det_code;
                    ns_n    = ALL_RED;
                    ew_n    = ALL_RED;
                end
            end
            FAULT_FLASH: begin
                if (clear_ok) begin
                    state_n = STARTUP;
                    code_n  = FC_NONE;
                end else begin
                    if (fcnt == F_END) begin
                        flash_n = ~flash;
                    end else begin
                        fcnt_n  = fcnt + FW'(1);
                        flash_n = flash;
                    end
                    ns_n = lamps_t'({3'b000, flash_n});
                    ew_n = lamps_t'({3'b000, flash_n});
                end
            end
            default: state_n = STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STARTUP;
            scnt    <= '0;
            persist <= '0;
            fcnt    <= '0;
            flash   <= 1'b1;
            code    <= FC_NONE;
            ns_q    <= ALL_RED;
            ew_q    <= ALL_RED;
        end else begin
            state   <= state_n;
            scnt    <= scnt_n;
            persist <= persist_n;
            fcnt    <= fcnt_n;
            flash   <= flash_n;
            code    <= code_n;
            ns_q    <= ns_n;
            ew_q    <= ew_n;
        end
    end

    assign bus.ns_green      = ns_q.green;
    assign bus.ns_left_green = ns_q.left_green;
    assign bus.ns_yellow     = ns_q.yellow;
    assign bus.ns_red        = ns_q.red;
    assign bus.ew_green      = ew_q.green;
    assign bus.ew_left_green = ew_q.left_green;
    assign bus.ew_yellow     = ew_q.yellow;
    assign bus.ew_red        = ew_q.red;
    assign bus.fault         = (state == FAULT_FLASH);
    assign bus.fault_code    = code;

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Sits directly downstream of the traffic_keke light controller, between its eight lamp outputs and the field lamp drivers.
- Registers the controller's lamp commands and passes them through.
- Checks the commands continuously for conflicting greens, invalid or dark aspects, and short yellow intervals.
- On any persistent fault it latches a fault code and overrides the field outputs with all-red flash until an operator clears it.

Parameters:
- CONFLICT_CYCLES, 3: consecutive cycles a conflict or invalid condition must persist before a fault latches (glitch filter).
- MIN_YELLOW, 30: minimum cycles a yellow aspect must be held before it is left.
- FLASH_HALF, 50: half-period of the fault red flash, in cycles.
- STARTUP_CYCLES, 20: cycles of solid all-red after reset or fault clear, before monitoring starts.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_ns_green, in_ns_left_green, in_ns_yellow, in_ns_red  in  1 each  NS commands from the controller.
- in_ew_green, in_ew_left_green, in_ew_yellow, in_ew_red  in  1 each  EW commands from the controller.
- clear_fault  in  1  single-cycle operator clear request.
- ns_green, ns_left_green, ns_yellow, ns_red  out  1 each  registered NS field lamp drives.
- ew_green, ew_left_green, ew_yellow, ew_red  out  1 each  registered EW field lamp drives.
- fault  out  1  high while in FAULT_FLASH.
- fault_code  out  2  00 none, 01 conflict, 10 invalid/dark, 11 short yellow.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to STARTUP and all counters clear.
  - ns_red = ew_red = 1; every other lamp output = 0.
  - fault = 0, fault_code = 00.
- Per-direction aspect groups:
  - go = green | left_green; green and left_green together is legal.
  - A direction is valid when exactly one of {go, yellow, red} is active.
  - Zero active aspects (dark) or two or more active aspects is invalid.
- Conflict: NS go and EW go active in the same cycle.
- Persistence counter:
  - Increments while conflict or invalid is present; clears to 0 on any clean cycle.
  - The fault latches on the cycle the counter reaches CONFLICT_CYCLES.
- Yellow timer (one per direction):
  - Counts while that direction's yellow input is high and saturates at MIN_YELLOW.
  - Clears to 0 when yellow is low.
  - Short-yellow fault: yellow falls while the timer is below MIN_YELLOW. This is immediate, with no persistence filter.
- Priority when several faults are detected in the same cycle: conflict > short yellow > invalid. Only the first fault's code is latched; later faults do not overwrite it.
- States:
  - STARTUP:
    - Outputs solid all-red; checks are disabled.
    - Counts STARTUP_CYCLES, then goes to MONITOR.
    - The yellow timers and persistence counter are held at 0.
  - MONITOR:
    - Outputs equal the inputs delayed by one register stage (1-cycle latency).
    - A fault detection moves to FAULT_FLASH on the next edge. In that same edge fault_code is loaded, fault = 1, and the outputs switch to flash.
  - FAULT_FLASH:
    - All green, left_green and yellow outputs = 0.
    - ns_red = ew_red = a flash bit that starts at 1 on entry and toggles every FLASH_HALF cycles.
    - Leaves to STARTUP when clear_fault = 1 in a cycle where the inputs are valid in both directions, non-conflicting, and show both directions red.
    - On that transition fault and fault_code clear.
    - clear_fault is ignored in every other state and in every other input condition.
- Simultaneous clear_fault and a new fault condition in FAULT_FLASH: stay in FAULT_FLASH, because the clear qualification fails.
- Counter widths are $clog2(param+1). All counters saturate and never wrap.

Decomposition:
- Shared package traffic_pkg holds:
  - the state enum (STARTUP, MONITOR, FAULT_FLASH);
  - the fault-code constants (FC_NONE, FC_CONFLICT, FC_INVALID, FC_SHORT_YEL).
- One sub-module, traffic_dir_checker, is instantiated once per direction. It takes the four aspect inputs and an enable, and produces go, valid, and a short_yellow pulse. It contains that direction's yellow timer.

Test Plan:
- Reset, then release at 50 ns → outputs stay all-red for 20 cycles. From cycle 21, outputs track the inputs with 1-cycle latency; fault = 0.
- In MONITOR, hold NS green and EW green high together for 2 cycles, then drop EW green → no fault. Hold them together for 3 cycles → fault = 1, fault_code = 01, outputs enter red flash with period 100 cycles.
- NS yellow held for 29 cycles then NS red → fault_code = 11. Repeat with 30 cycles → no fault.
- NS shows yellow and red together for 3 cycles → fault_code = 10. Drive NS dark for 3 cycles → fault_code = 10.
- In FAULT_FLASH, pulse clear_fault while NS green is active → ignored. Set both directions red, then pulse clear_fault → STARTUP, fault = 0, 20 cycles solid red, then MONITOR.
- Assert rst in mid-flash → next output is solid all-red, fault = 0 and fault_code = 00 asynchronously, and STARTUP sequencing restarts.
